mips_cpu_muldiv_unit: RTL and testbench
=======================================

# mips_cpu_muldiv_unit

Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS CPU family. It replaces single-cycle combinational `*`, `/` and `%` with an iterative shift-add multiplier and a restoring divider. It owns the HI and LO architectural registers and reports `busy` so the CPU core can stall on MFHI/MFLO, MULT*, DIV* and MTHI/MTLO while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; minimum 4.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `clk_enable`  in  1  when low, all state including the iteration counter is frozen.
- `start`  in  1  request an operation; sampled on a clk_enable edge while `busy`=0.
- `op`  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `mt_write`  in  1  MTHI/MTLO request; sampled like `start`.
- `mt_sel`  in  1  0 writes LO, 1 writes HI.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are updated by an operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - `start` accepted: latch the operand magnitudes and signs from `op` (signed ops take the absolute value); clear the accumulator; counter = WIDTH−1; go to RUN.
  - `mt_write` without `start`: write `a` into HI or LO per `mt_sel`; stay in IDLE.
- **RUN**
  - Multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
  - Divide: one restoring step per cycle.
  - At counter 0, go to FIX.
- **FIX**
  - Apply sign correction: the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Write HI and LO, then go to IDLE.
- Divide by zero: LO = all ones, HI = `a`, for both DIV and DIVU. The full latency still applies.
- DIV of most-negative by −1: LO = most-negative value (wraps), HI = 0.
- Requests while `busy`=1: `start` and `mt_write` are ignored with no side effects. The core must stall.
- Simultaneous `start` and `mt_write`: `start` wins and `mt_write` is dropped.
- HI/LO are not modified during RUN. The `hi`/`lo` outputs always show the committed values.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE.
- Reset mid-operation: the operation is abandoned and every output returns to its reset value on the next edge.
- Accept edge is E0. After E0, `busy`=1.
- Edges E1..E_WIDTH are the RUN steps. Edge E_(WIDTH+1) is FIX: HI/LO are written, `busy`=0 and `done`=1 for one cycle.
- Latency from the accept edge to HI/LO valid is WIDTH+1 enabled cycles. Cycles with `clk_enable` low extend it one-for-one.
- A new `start` can be accepted in the cycle `done` is high (back-to-back throughput WIDTH+2).
- MT write: HI/LO are updated on the accept edge. No `busy`, no `done`.

## Configuration
- Macro `MULDIV_FAST_MULT_EN`.
- Defined: MULT/MULTU use a combinational WIDTH×WIDTH product captured in FIX. The path is IDLE→FIX, `busy` is high for exactly one cycle, and latency is 1. Divide is unchanged.
- Undefined: the iterative multiplier is used, latency WIDTH+1.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU);
  - the `muldiv_state_t` FSM enum;
  - the existing opcode, function and ALU-control enums, moved out of the CPU tops.
- Sub-module `mips_cpu_divider_iter` implements the unsigned restoring step datapath (remainder/quotient registers plus one subtract-compare per cycle). The unit wraps it with sign handling and the multiplier.

## Test plan
All scenarios use WIDTH=32 with the macro undefined unless stated.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `busy` for 33 cycles; `done` pulses once.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. With `MULDIV_FAST_MULT_EN` defined, the same result is produced with `busy` high for 1 cycle.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5 after 33 cycles.
- `start` (DIVU 100/7) with `mt_write` pulsed at cycle 5 and `clk_enable` low for cycles 10–12 → `mt_write` ignored; LO=14, HI=2; latency 36.
- Idle `mt_write`, `mt_sel`=1, `a`=0x1234 → HI=0x1234 next edge. Then start MULTU and assert `reset` at iteration 10 → HI=LO=0, `busy`=0, no `done`.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU package: multiply/divide unit enums plus the opcode,
// function and ALU-control encodings used by the CPU tops.
package mips_cpu_pkg;

  // HI/LO unit operation, encoded as the low two bits of funct 0x18..0x1B.
  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'd0,
    MULDIV_MULTU = 2'd1,
    MULDIV_DIV   = 2'd2,
    MULDIV_DIVU  = 2'd3
  } muldiv_op_t;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_t;

  // Primary opcode field (instr[31:26]).
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C,
    OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F, OP_LB    = 6'h20,
    OP_LH      = 6'h21, OP_LWL    = 6'h22, OP_LW    = 6'h23, OP_LBU   = 6'h24,
    OP_LHU     = 6'h25, OP_LWR    = 6'h26, OP_SB    = 6'h28, OP_SH    = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  // SPECIAL function field (instr[5:0]).
  typedef enum logic [5:0] {
    FN_SLL   = 6'h00, FN_SRL   = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06, FN_SRAV  = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09,
    FN_MFHI  = 6'h10, FN_MTHI  = 6'h11, FN_MFLO  = 6'h12, FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18, FN_MULTU = 6'h19, FN_DIV   = 6'h1A, FN_DIVU  = 6'h1B,
    FN_ADDU  = 6'h21, FN_SUBU  = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25,
    FN_XOR   = 6'h26, FN_NOR   = 6'h27, FN_SLT   = 6'h2A, FN_SLTU  = 6'h2B
  } funct_t;

  // ALU control produced by the decoder.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND  = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT  = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA  = 4'd10, ALU_LUI = 4'd11
  } alu_ctrl_t;

  function automatic logic muldiv_is_signed(muldiv_op_t op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

  function automatic logic muldiv_is_div(muldiv_op_t op);
    return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_unit_if.sv
// Request/response bundle between the CPU core (master) and the HI/LO
// multiply/divide unit (slave).
//
// Handshake: start and mt_write are requests that the unit takes on any
// clock edge where clk_enable is high and busy is low; busy doubles as the
// inverted ready. Requests presented while busy is high are dropped without
// side effects, so the core must hold off (stall) until busy falls. When
// both are raised together start is taken and mt_write is dropped. done is
// a one-cycle pulse telling the core that hi/lo carry a fresh result.
interface mips_cpu_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_write;
  logic             mt_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, mt_write, mt_sel,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mt_write, mt_sel,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_divider_iter.sv
// Unsigned restoring divider datapath: one shift/subtract/compare per step.
// After WIDTH steps quotient holds dividend/divisor and remainder holds
// dividend%divisor. A zero divisor yields all-ones quotient bits (masked by
// the caller) and a remainder equal to the dividend.
module mips_cpu_divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Partial remainder shifted left by one dividend bit, then trial-subtracted.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  // Load operands, or keep/restore the trial difference one bit at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit. Owns HI and LO, runs MULT/MULTU
// on an iterative shift-add multiplier and DIV/DIVU on a restoring divider,
// applies sign correction in a final FIX cycle, and handles MTHI/MTLO.
// Optional feature macro: MULDIV_FAST_MULT_EN -- multiplies use a single
// combinational product captured in FIX (IDLE->FIX, one busy cycle).
module mips_cpu_muldiv_unit
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_enable,
  mips_cpu_muldiv_unit_if.slave  bus,
  output muldiv_state_t          fsm_state
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state;
  logic [CW-1:0]    count;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  muldiv_op_t       req_op;
  logic             req_signed;
  logic             req_a_neg;
  logic             req_b_neg;
  logic [WIDTH-1:0] req_a_mag;
  logic [WIDTH-1:0] req_b_mag;
  logic             accept;
  logic             op_div;
  logic             sign_diff;

  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  // Request decode: signed ops work on magnitudes and remember the signs.
  assign req_op     = muldiv_op_t'(bus.op);
  assign req_signed = muldiv_is_signed(req_op);
  assign req_a_neg  = req_signed & bus.a[WIDTH-1];
  assign req_b_neg  = req_signed & bus.b[WIDTH-1];
  assign req_a_mag  = req_a_neg ? -bus.a : bus.a;
  assign req_b_mag  = req_b_neg ? -bus.b : bus.b;
  assign accept     = clk_enable & (state == MD_IDLE) & bus.start;
  assign op_div     = muldiv_is_div(op_q);
  assign sign_diff  = a_neg ^ b_neg;

  mips_cpu_divider_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (clk_enable & (state == MD_RUN) & op_div),
    .dividend  (req_a_mag),
    .divisor   (b_mag),
    .quotient  (q_mag),
    .remainder (r_mag)
  );

`ifdef MULDIV_FAST_MULT_EN
  assign prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
  // Accumulator {partial product, remaining multiplier bits}; the adder keeps
  // its carry so the right shift brings it into the upper half.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     acc_sum;
  assign acc_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign prod_mag = acc;
`endif

  // Sign fix-up; the remainder follows the dividend, which also makes a
  // divide by zero return the original dividend in HI.
  assign prod_res = sign_diff ? -prod_mag : prod_mag;
  assign quo_res  = (b_mag == '0) ? '1 : (sign_diff ? -q_mag : q_mag);
  assign rem_res  = a_neg ? -r_mag : r_mag;

  // Sequencer: IDLE accepts requests, RUN iterates, FIX commits HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      count  <= '0;
      op_q   <= MULDIV_MULT;
      a_mag  <= '0;
      b_mag  <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifndef MULDIV_FAST_MULT_EN
      acc    <= '0;
`endif
    end else if (clk_enable) begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.start) begin
            op_q   <= req_op;
            a_mag  <= req_a_mag;
            b_mag  <= req_b_mag;
            a_neg  <= req_a_neg;
            b_neg  <= req_b_neg;
            count  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            state  <= muldiv_is_div(req_op) ? MD_RUN : MD_FIX;
`else
            acc    <= {{WIDTH{1'b0}}, req_b_mag};
            state  <= MD_RUN;
`endif
          end else if (bus.mt_write) begin
            if (bus.mt_sel) hi_q <= bus.a;
            else            lo_q <= bus.a;
          end
        end
        MD_RUN: begin
`ifndef MULDIV_FAST_MULT_EN
          if (!op_div) acc <= {acc_sum, acc[WIDTH-1:1]};
`endif
          if (count == '0) state <= MD_FIX;
          else             count <= count - CW'(1);
        end
        MD_FIX: begin
          if (op_div) begin
            hi_q <= rem_res;
            lo_q <= quo_res;
          end else begin
            {hi_q, lo_q} <= prod_res;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit: a table of directed
// multiply/divide vectors plus hand-written sequences for MT writes,
// request collisions, clock-enable stalls, back-to-back issue and reset.
module tb_mips_cpu_muldiv_unit;
  import mips_cpu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  muldiv_state_t fsm_state;

  always #5 clk = ~clk;

  mips_cpu_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_cpu_muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  hi_model;
  logic [W-1:0]  lo_model;

  typedef struct {
    muldiv_op_t   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input muldiv_op_t op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] hi,
                         input logic [W-1:0] lo, input string name);
    vecs[i].op = op; vecs[i].a = a; vecs[i].b = b;
    vecs[i].hi = hi; vecs[i].lo = lo; vecs[i].name = name;
  endtask

  function automatic int exp_latency(input muldiv_op_t op);
`ifdef MULDIV_FAST_MULT_EN
    if (op == MULDIV_MULT || op == MULDIV_MULTU) return 1;
`endif
    return W + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents a start for one edge and queues the result.
  task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mtw, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.mt_write = mtw;
    bus.mt_sel   = 1'b1;
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.mt_write = 1'b0;
  endtask

  // Counts busy cycles (bounded), optionally pulses mt_write and drops
  // clk_enable at given busy cycles, then checks the committed result.
  task automatic wait_done(input string name, input int exp_lat, input int mt_cyc,
                           input int st_lo, input int st_hi);
    int           cyc;
    logic         hold_ok;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    cyc     = 0;
    hold_ok = 1'b1;
    while (bus.busy === 1'b1 && cyc < 200) begin
      if (bus.hi !== hi_model || bus.lo !== lo_model || bus.done !== 1'b0) hold_ok = 1'b0;
      bus.mt_write = (cyc == mt_cyc);
      if (cyc == mt_cyc) begin
        bus.mt_sel = 1'b0;
        bus.a      = 32'h0000_DEAD;
      end
      clk_enable = !(cyc >= st_lo && cyc <= st_hi);
      cyc++;
      @(negedge clk);
    end
    bus.mt_write = 1'b0;
    clk_enable   = 1'b1;
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_hold"}, 64'(hold_ok), 64'(1));
    check({name, "_done"}, 64'(bus.done), 64'(1));
    check({name, "_hi"}, 64'(bus.hi), 64'(e_hi));
    check({name, "_lo"}, 64'(bus.lo), 64'(e_lo));
    hi_model = e_hi;
    lo_model = e_lo;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic saw_done;
    logic saw_busy;

    set_vec(0,  MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    set_vec(1,  MULDIV_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
    set_vec(2,  MULDIV_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    set_vec(3,  MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_minneg");
    set_vec(4,  MULDIV_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0");
    set_vec(5,  MULDIV_DIV,   32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_neg_by0");
    set_vec(6,  MULDIV_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq");
    set_vec(7,  MULDIV_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2");
    set_vec(8,  MULDIV_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7");
    set_vec(9,  MULDIV_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_shift");
    set_vec(10, MULDIV_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by1");
    set_vec(11, MULDIV_MULT,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "mult_5xm1");

    // Reset state
    reset        = 1'b1;
    clk_enable   = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.mt_write = 1'b0;
    bus.mt_sel   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi",    64'(bus.hi),   64'(0));
    check("rst_lo",    64'(bus.lo),   64'(0));
    check("rst_busy",  64'(bus.busy), 64'(0));
    check("rst_done",  64'(bus.done), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(MD_IDLE));
    reset    = 1'b0;
    hi_model = '0;
    lo_model = '0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check({vecs[i].name, "_done_clr"}, 64'(bus.done), 64'(0));
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].hi, vecs[i].lo);
      wait_done(vecs[i].name, exp_latency(vecs[i].op), -1, -1, -1);
    end

    // start and mt_write together: start wins, HI must not take a
    @(negedge clk);
    issue(MULDIV_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    wait_done("start_wins", exp_latency(MULDIV_MULTU), -1, -1, -1);

    // Back-to-back issue in the done cycle, mt_write during busy and
    // clk_enable low for three busy cycles
    issue(MULDIV_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    wait_done("divu_stall", W + 4, 5, 10, 12);

    // Idle MTHI then MTLO
    @(negedge clk);
    bus.mt_write = 1'b1;
    bus.mt_sel   = 1'b1;
    bus.a        = 32'h0000_1234;
    @(negedge clk);
    bus.mt_write = 1'b0;
    check("mthi_hi",   64'(bus.hi),   64'(32'h0000_1234));
    check("mthi_lo",   64'(bus.lo),   64'(lo_model));
    check("mthi_busy", 64'(bus.busy), 64'(0));
    check("mthi_done", 64'(bus.done), 64'(0));
    hi_model = 32'h0000_1234;
    bus.mt_write = 1'b1;
    bus.mt_sel   = 1'b0;
    bus.a        = 32'h0000_ABCD;
    @(negedge clk);
    bus.mt_write = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'(32'h0000_ABCD));
    check("mtlo_hi", 64'(bus.hi), 64'(hi_model));
    lo_model = 32'h0000_ABCD;

    // Reset in the middle of a MULTU
    bus.start = 1'b1;
    bus.op    = MULDIV_MULTU;
    bus.a     = 32'h0000_1234;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("midrst_busy_before", 64'(bus.busy), 64'(1));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi",    64'(bus.hi),    64'(0));
    check("midrst_lo",    64'(bus.lo),    64'(0));
    check("midrst_busy",  64'(bus.busy),  64'(0));
    check("midrst_done",  64'(bus.done),  64'(0));
    check("midrst_state", 64'(fsm_state), 64'(MD_IDLE));
    hi_model = '0;
    lo_model = '0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
      saw_busy = saw_busy | bus.busy;
    end
    check("midrst_no_done", 64'(saw_done), 64'(0));
    check("midrst_no_busy", 64'(saw_busy), 64'(0));

    // Unit still works after the abandoned operation
    issue(MULDIV_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done("mult_after_rst", exp_latency(MULDIV_MULT), -1, -1, -1);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
